// File: rtl/lookahead_sum_if.sv
// Beat bus for the lookahead sum stage: upstream lookahead vectors in, registered sum beats out.
interface lookahead_sum_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_p;
  logic [WIDTH-1:0] in_g;
  logic [WIDTH-1:0] in_pp;
  logic             in_cin;
  logic             in_first;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_first;
  logic             out_last;
  logic [CNT_W-1:0] out_idx;
  logic             err_seq;

  modport master (
    output in_valid, in_p, in_g, in_pp, in_cin, in_first, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_first, out_last, out_idx, err_seq
  );

  modport slave (
    input  in_valid, in_p, in_g, in_pp, in_cin, in_first, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_first, out_last, out_idx, err_seq
  );
endinterface

// File: rtl/lookahead_sum_stage.sv
// Final sum stage of a carry-lookahead adder: applies the real carry-in, chains carry across
// beats of a multi-word add, and registers results in a 2-entry skid buffer.
module lookahead_sum_stage #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input logic           clk,
  input logic           rst_n,
  lookahead_sum_if.slave bus
);
  typedef enum logic {IDLE = 1'b0, CHAIN = 1'b1} state_t;

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             first;
    logic             last;
    logic [CNT_W-1:0] idx;
  } beat_t;

  localparam logic [CNT_W-1:0] IDX_MAX = '1;

  function automatic logic [WIDTH-1:0] carry_vec(input logic [WIDTH-1:0] g,
                                                 input logic [WIDTH-1:0] pp,
                                                 input logic             ci);
    logic [WIDTH-1:0] c;
    c[0] = ci;
    for (int i = 0; i < WIDTH-1; i++) c[i+1] = g[i] | (pp[i] & ci);
    return c;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == IDX_MAX) ? v : v + 1'b1;
  endfunction

  state_t           state_q, state_d;
  logic             carry_q;
  logic [CNT_W-1:0] idx_q;
  logic             err_q;
  beat_t            skid_p1 [2];
  logic             wr_ptr_q, rd_ptr_q;
  logic [1:0]       cnt_q;

  logic             push, pop, restart, ci, err_d;
  logic [CNT_W-1:0] idx_d;
  beat_t            beat_p0, head_p1;

  // Ready comes only from the registered count, so a full buffer refuses even while draining.
  assign bus.in_ready = (cnt_q != 2'd2);
  assign push         = bus.in_valid & bus.in_ready;
  assign pop          = (cnt_q != 2'd0) & bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (push) state_d = bus.in_last ? IDLE : CHAIN;
  end

  // A beat restarts the chain from IDLE or when it claims first; both misuses raise err_seq.
  always_comb begin
    restart       = (state_q == IDLE) | bus.in_first;
    ci            = restart ? bus.in_cin : carry_q;
    idx_d         = restart ? '0 : sat_inc(idx_q);
    err_d         = push & ((state_q == IDLE) ? ~bus.in_first : bus.in_first);
    beat_p0       = '0;
    beat_p0.sum   = bus.in_p ^ carry_vec(bus.in_g, bus.in_pp, ci);
    beat_p0.cout  = bus.in_g[WIDTH-1] | (bus.in_pp[WIDTH-1] & ci);
    beat_p0.first = restart;
    beat_p0.last  = bus.in_last;
    beat_p0.idx   = idx_d;
  end

  // Stage p0 -> p1: chain state and skid buffer storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_q  <= 1'b0;
      idx_q    <= '0;
      err_q    <= 1'b0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
      for (int i = 0; i < 2; i++) skid_p1[i] <= '0;
    end else begin
      err_q <= err_d;
      if (push) begin
        carry_q           <= beat_p0.cout;
        idx_q             <= idx_d;
        skid_p1[wr_ptr_q] <= beat_p0;
        wr_ptr_q          <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 2'd1;
        2'b01:   cnt_q <= cnt_q - 2'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign head_p1       = (cnt_q != 2'd0) ? skid_p1[rd_ptr_q] : '0;
  assign bus.out_valid = (cnt_q != 2'd0);
  assign bus.out_sum   = head_p1.sum;
  assign bus.out_cout  = head_p1.cout;
  assign bus.out_first = head_p1.first;
  assign bus.out_last  = head_p1.last;
  assign bus.out_idx   = head_p1.idx;
  assign bus.err_seq   = err_q;
endmodule

// File: tb/tb_lookahead_sum_stage.sv
// Directed bench for lookahead_sum_stage: operands drive the lookahead vectors, a queue holds expected beats.
module tb_lookahead_sum_stage;
  localparam int WIDTH = 16;
  localparam int CNT_W = 8;

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             first;
    logic             last;
    logic [CNT_W-1:0] idx;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lookahead_sum_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();
  lookahead_sum_stage #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  exp_t sbq[$];
  int   n_checks = 0;
  int   n_fails  = 0;
  bit   m_chain  = 0;
  logic m_carry  = 0;
  int   m_idx    = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic exp_t out_now();
    exp_t o;
    o = '{bus.out_sum, bus.out_cout, bus.out_first, bus.out_last, bus.out_idx};
    return o;
  endfunction

  // Drive one beat built from operands a,b; wait (bounded) for acceptance and record the expectation.
  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic cin, input logic first, input logic last);
    logic [WIDTH-1:0] p, g, gp, pp;
    logic [WIDTH:0]   total;
    logic             restart, err, ci;
    int               idx, waited;
    exp_t             e;
    p = a ^ b;
    g = a & b;
    gp[0] = g[0];
    pp[0] = p[0];
    for (int i = 1; i < WIDTH; i++) begin
      gp[i] = g[i] | (p[i] & gp[i-1]);
      pp[i] = p[i] & pp[i-1];
    end
    bus.in_p = p; bus.in_g = gp; bus.in_pp = pp;
    bus.in_cin = cin; bus.in_first = first; bus.in_last = last;
    bus.in_valid = 1'b1;
    waited = 0;
    @(negedge clk);
    while (!bus.in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.in_ready) begin
      check("accept_timeout", 64'd0, 64'd1);
      bus.in_valid = 1'b0;
      return;
    end
    restart = !m_chain || first;
    err     = m_chain ? first : !first;
    ci      = restart ? cin : m_carry;
    total   = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, ci};
    idx     = restart ? 0 : ((m_idx == 255) ? 255 : m_idx + 1);
    e       = '{total[WIDTH-1:0], total[WIDTH], restart, last, idx[CNT_W-1:0]};
    sbq.push_back(e);
    m_carry = total[WIDTH];
    m_chain = !last;
    m_idx   = idx;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check("err_seq", {63'd0, bus.err_seq}, {63'd0, err});
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (sbq.size() == 0) check("unexpected_beat", 64'd1, 64'd0);
      else check("beat", {30'd0, out_now()}, {30'd0, sbq.pop_front()});
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    exp_t snap;
    int   w;
    bus.in_valid = 0; bus.in_p = '0; bus.in_g = '0; bus.in_pp = '0;
    bus.in_cin = 0; bus.in_first = 0; bus.in_last = 0; bus.out_ready = 1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("reset_in_ready",  {63'd0, bus.in_ready},  64'd1);
    check("reset_outs",      {30'd0, out_now()},     64'd0);
    check("reset_err",       {63'd0, bus.err_seq},   64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // single beat FFFF + 0 + cin=1, then a two-beat chain
    send(16'hFFFF, 16'h0000, 1'b1, 1'b1, 1'b1);
    check("latency_valid", {63'd0, bus.out_valid}, 64'd1);
    @(posedge clk); #1;
    send(16'hFFFF, 16'h0000, 1'b1, 1'b1, 1'b0);
    send(16'h0001, 16'h0000, 1'b0, 1'b0, 1'b1);
    repeat (2) @(posedge clk); #1;

    // backpressure: two beats fill the buffer, third waits until release
    bus.out_ready = 1'b0;
    send(16'h1234, 16'h4321, 1'b0, 1'b1, 1'b0);
    send(16'hF000, 16'h1000, 1'b0, 1'b0, 1'b0);
    check("full_in_ready", {63'd0, bus.in_ready}, 64'd0);
    snap = out_now();
    check("full_head", {30'd0, snap}, {30'd0, sbq[0]});
    fork
      send(16'h0F0F, 16'h00F1, 1'b1, 1'b0, 1'b1);
      begin
        repeat (3) begin
          @(negedge clk);
          check("hold_stable", {30'd0, out_now()}, {30'd0, snap});
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
      end
    join
    repeat (3) @(posedge clk); #1;

    // first=0 while idle: treated as first, err_seq flagged
    send(16'h1234, 16'h1111, 1'b0, 1'b0, 1'b1);
    @(posedge clk); #1;
    check("err_one_pulse", {63'd0, bus.err_seq}, 64'd0);

    // reset mid-chain with a full buffer
    bus.out_ready = 1'b0;
    send(16'hAAAA, 16'h5555, 1'b0, 1'b1, 1'b0);
    send(16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("rst_in_ready",  {63'd0, bus.in_ready},  64'd1);
    sbq.delete();
    m_chain = 0; m_carry = 0; m_idx = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    send(16'h00FF, 16'h0001, 1'b1, 1'b0, 1'b1);

    // random short chains
    for (int k = 0; k < 20; k++)
      send(16'($urandom), 16'($urandom), 1'($urandom), (k % 4) == 0, (k % 4) == 3);

    // long chain: index saturates
    for (int k = 0; k < 300; k++)
      send(16'hFFFF, 16'h0000, 1'b1, k == 0, k == 299);

    w = 0;
    while (sbq.size() != 0 && w < 100) begin
      @(posedge clk);
      w++;
    end
    #1;
    check("drain_empty", 64'(sbq.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
